// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver:
// FSM state codes, debounce integrator limits and status word bit positions.
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE      = 3'd0;
  localparam ps2_state_t ST_INHIBIT   = 3'd1;
  localparam ps2_state_t ST_RTS       = 3'd2;
  localparam ps2_state_t ST_BITS      = 3'd3;
  localparam ps2_state_t ST_ACK       = 3'd4;
  localparam ps2_state_t ST_WAIT_IDLE = 3'd5;

  localparam int              DEB_W    = 6;
  localparam logic [DEB_W-1:0] DEB_INIT = 6'd32;
  localparam logic [DEB_W-1:0] DEB_MAX  = 6'd63;
  localparam logic [DEB_W-1:0] DEB_MIN  = 6'd0;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ACK_ERR = 2;
  localparam int STAT_TIMEOUT = 3;

  // Odd parity bit: 1 when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_debounce.sv
// Synchronises one raw PS/2 line and filters it with a saturating integrator.
// The output only changes once the integrator hits a rail, so short glitches
// on the open-drain bus never reach the protocol logic.
module ps2_debounce
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filtered
);

  logic [1:0]       sync;
  logic [DEB_W-1:0] integ;

  // Two-flop synchroniser; idles high like the released bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], raw};
  end

  // Integrate toward the synchronised level and flip the output at the rails.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ    <= DEB_INIT;
      filtered <= 1'b1;
    end else begin
      if (sync[1] && integ != DEB_MAX)
        integ <= integ + 1'b1;
      else if (!sync[1] && integ != DEB_MIN)
        integ <= integ - 1'b1;
      if (integ == DEB_MAX)
        filtered <= 1'b1;
      else if (integ == DEB_MIN)
        filtered <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter. Inhibits the bus, issues
// request-to-send, shifts data/parity/stop on device clock falling edges,
// checks the device ack and guards every device-paced phase with a timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int RTS_CYCLES     = 25,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_data,
  input  logic        ps2_clk,
  output logic        ps2_data_oe,
  output logic        ps2_clk_oe,
  input  logic        valid,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int PMAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t  state;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  tx_byte;
  logic        tx_parity;
  logic        done, ack_err, timeout_err;
  logic        clk_deb, data_deb, clk_deb_q;
  logic        dev_fall, to_hit, next_bit;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];
  assign dev_fall     = clk_deb_q & ~clk_deb;
  assign to_hit       = (to_cnt == TO_LAST);

  ps2_debounce u_clk_deb  (.clk(clk), .rst(rst), .raw(ps2_clk),  .filtered(clk_deb));
  ps2_debounce u_data_deb (.clk(clk), .rst(rst), .raw(ps2_data), .filtered(data_deb));

  // Delayed copy of the filtered clock for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_deb_q <= 1'b1;
    else     clk_deb_q <= clk_deb;
  end

  // Frame bit to present for the current counter value: data LSB first, parity, stop.
  always_comb begin
    next_bit = 1'b1;
    if (bit_cnt < 4'd8)
      next_bit = tx_byte[bit_cnt[2:0]];
    else if (bit_cnt == 4'd8)
      next_bit = tx_parity;
  end

  // Status word seen by the bus, assembled from the current flags.
  always_comb begin
    status               = '0;
    status[STAT_BUSY]    = busy;
    status[STAT_DONE]    = done;
    status[STAT_ACK_ERR] = ack_err;
    status[STAT_TIMEOUT] = timeout_err;
  end

  // Capture status on every bus access, before any flag update of that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (valid) rdata <= status;
  end

  // Transfer sequencer: bus inhibit, request-to-send, bit shifting, ack, release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      phase_cnt   <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      tx_byte     <= '0;
      tx_parity   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            tx_byte     <= wdata[7:0];
            tx_parity   <= odd_parity(wdata[7:0]);
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            phase_cnt   <= '0;
            state       <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (phase_cnt == INH_LAST) begin
            phase_cnt   <= '0;
            ps2_data_oe <= 1'b1;
            state       <= ST_RTS;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_RTS: begin
          if (phase_cnt == RTS_LAST) begin
            phase_cnt  <= '0;
            ps2_clk_oe <= 1'b0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            state      <= ST_BITS;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_BITS: begin
          if (dev_fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              ps2_data_oe <= 1'b0;
              state       <= ST_ACK;
            end else begin
              ps2_data_oe <= ~next_bit;
              bit_cnt     <= bit_cnt + 1'b1;
            end
          end else if (to_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (dev_fall) begin
            to_cnt <= '0;
            if (!data_deb) done    <= 1'b1;
            else           ack_err <= 1'b1;
            state <= ST_WAIT_IDLE;
          end else if (to_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (clk_deb && data_deb) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple device
// model that clocks frames in, samples each bit and optionally acknowledges.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int RTS  = 10;
  localparam int TO   = 2000;
  localparam int HALF = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        ps2_clk_oe, ps2_data_oe;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;
  wire         ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  wire         ps2_data_line = ~(ps2_data_oe | dev_data_low);

  int          vectors = 0;
  int          miscompares = 0;
  int          pulse_num = 0;
  logic [10:0] frame;
  logic        dev_ok;
  int          n, m;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_data(ps2_data_line),
    .ps2_clk(ps2_clk_line),
    .ps2_data_oe(ps2_data_oe),
    .ps2_clk_oe(ps2_clk_oe),
    .valid(valid),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    valid = 1'b1;
    wdata = {24'hA5A5A5, b};
    @(negedge clk);
    valid = 1'b0;
  endtask

  // frame[0] start, frame[8:1] data, frame[9] parity, frame[10] stop
  task automatic deviceTransfer(input int pulses, input bit do_ack,
                                output logic [10:0] fr, output logic ok);
    int w;
    fr = '1;
    ok = 1'b0;
    w  = 0;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) return;
    ok = 1'b1;
    repeat (150) @(negedge clk);
    fr[0] = ps2_data_line;
    for (int k = 1; k <= pulses; k++) begin
      if (k == 11) begin
        if (do_ack) dev_data_low = 1'b1;
        repeat (100) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      pulse_num   = k;
      repeat (HALF) @(negedge clk);
      if (k <= 10) fr[k] = ps2_data_line;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic waitIdle(input string tag);
    int w;
    w = 0;
    while (busy && w < 2000) begin
      @(negedge clk);
      w++;
    end
    checkOutput(tag, busy, 0);
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_clk_oe", ps2_clk_oe, 0);
    checkOutput("reset_data_oe", ps2_data_oe, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rdata", rdata, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // 0xED with ack, phase lengths measured
    applyStimulus(8'hED);
    checkOutput("ed_rdata_pre", rdata, 32'h0);
    checkOutput("ed_busy", busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin n++; @(negedge clk); end
    checkOutput("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 1000) begin n++; @(negedge clk); end
    checkOutput("rts_len", n, RTS);
    deviceTransfer(11, 1'b1, frame, dev_ok);
    checkOutput("ed_rts_seen", dev_ok, 1);
    checkOutput("ed_start", frame[0], 0);
    checkOutput("ed_data", frame[8:1], 8'hED);
    checkOutput("ed_parity", frame[9], 1);
    checkOutput("ed_stop", frame[10], 1);
    waitIdle("ed_idle");

    // 0x01: parity 0
    applyStimulus(8'h01);
    checkOutput("ed_rdata_done", rdata, 32'h2);
    deviceTransfer(11, 1'b1, frame, dev_ok);
    checkOutput("x01_data", frame[8:1], 8'h01);
    checkOutput("x01_parity", frame[9], 0);
    waitIdle("x01_idle");

    // 0x00: parity 1
    applyStimulus(8'h00);
    checkOutput("x01_rdata_done", rdata, 32'h2);
    deviceTransfer(11, 1'b1, frame, dev_ok);
    checkOutput("x00_data", frame[8:1], 8'h00);
    checkOutput("x00_parity", frame[9], 1);
    waitIdle("x00_idle");

    // 0xFF: parity 1, device withholds ack
    applyStimulus(8'hFF);
    checkOutput("x00_rdata_done", rdata, 32'h2);
    deviceTransfer(11, 1'b0, frame, dev_ok);
    checkOutput("xff_data", frame[8:1], 8'hFF);
    checkOutput("xff_parity", frame[9], 1);
    waitIdle("noack_idle");

    // device never clocks: timeout
    applyStimulus(8'h12);
    checkOutput("noack_rdata", rdata, 32'h4);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin @(negedge clk); n++; end
    m = 0;
    while (busy && m < 10000) begin @(negedge clk); m++; end
    checkOutput("timeout_len", m, TO);
    checkOutput("timeout_clk_oe", ps2_clk_oe, 0);
    checkOutput("timeout_data_oe", ps2_data_oe, 0);

    // 0xED with a second valid (0x55) mid-transfer
    applyStimulus(8'hED);
    checkOutput("timeout_rdata", rdata, 32'h8);
    pulse_num = 0;
    fork
      deviceTransfer(11, 1'b1, frame, dev_ok);
      begin
        n = 0;
        while (pulse_num < 3 && n < 20000) begin @(negedge clk); n++; end
        repeat (50) @(negedge clk);
        applyStimulus(8'h55);
        checkOutput("busy_rdata", rdata, 32'h1);
      end
    join
    checkOutput("ignored_data", frame[8:1], 8'hED);
    checkOutput("ignored_parity", frame[9], 1);
    waitIdle("ignored_idle");

    // 0x55 sent on its own
    applyStimulus(8'h55);
    checkOutput("ignored_rdata_done", rdata, 32'h2);
    deviceTransfer(11, 1'b1, frame, dev_ok);
    checkOutput("x55_data", frame[8:1], 8'h55);
    checkOutput("x55_parity", frame[9], 1);
    waitIdle("x55_idle");

    // reset during bit 4 of 0xED
    applyStimulus(8'hED);
    checkOutput("x55_rdata_done", rdata, 32'h2);
    pulse_num = 0;
    fork
      deviceTransfer(5, 1'b1, frame, dev_ok);
      begin
        n = 0;
        while (pulse_num < 5 && n < 20000) begin @(negedge clk); n++; end
        repeat (120) @(negedge clk);
        checkOutput("bit4_data_oe", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_clk_oe", ps2_clk_oe, 0);
        checkOutput("midrst_data_oe", ps2_data_oe, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_rdata", rdata, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (300) @(negedge clk);

    // 0xF4 after reset: no flags left over, parity 0
    applyStimulus(8'hF4);
    checkOutput("f4_rdata_pre", rdata, 32'h0);
    deviceTransfer(11, 1'b1, frame, dev_ok);
    checkOutput("f4_data", frame[8:1], 8'hF4);
    checkOutput("f4_parity", frame[9], 0);
    checkOutput("f4_stop", frame[10], 1);
    waitIdle("f4_idle");
    applyStimulus(8'h00);
    checkOutput("f4_rdata_done", rdata, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
